// File: rtl/switch_event_source.sv
// switch_event_source: synchronizes 18 raw switches, records toggles in a pending
// mask and reports them one at a time (lowest index first) over a request/acknowledge pair.
module switch_event_source #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] switches,
    input  logic        resetActive,
    output logic [5:0]  number,
    output logic        active,
    output logic [17:0] pending,
    output logic        coalesced,
    output logic        timeout
);

    typedef enum logic [1:0] {
        PRIME,
        IDLE,
        BUSY,
        GAP
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,     state_d;
    logic [1:0]  prime_cnt_q, prime_cnt_d;
    logic [7:0]  busy_cnt_q,  busy_cnt_d;
    logic [17:0] sync_meta_q, sync_meta_d;
    logic [17:0] sync_q,      sync_d;
    logic [17:0] prev_q,      prev_d;
    logic [17:0] pending_q,   pending_d;
    logic [5:0]  number_q,    number_d;
    logic        active_q,    active_d;
    logic        coalesced_q, coalesced_d;
    logic        timeout_q,   timeout_d;

    logic [17:0] toggle;
    logic [17:0] clear_mask;
    logic [4:0]  lowest_idx;

    // Scanning from the top down leaves the lowest set index as the final assignment.
    always_comb begin
        lowest_idx = 5'd0;
        for (int i = 17; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_idx = 5'(i);
            end
        end
    end

    always_comb begin
        sync_meta_d = switches;
        sync_d      = sync_meta_q;
        prev_d      = sync_q;
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        busy_cnt_d  = busy_cnt_q;
        number_d    = number_q;
        active_d    = active_q;
        timeout_d   = timeout_q;
        clear_mask  = '0;
        toggle      = (state_q == PRIME) ? '0 : (sync_q ^ prev_q);

        case (state_q)
            PRIME: begin
                prime_cnt_d = prime_cnt_q + 2'd1;
                if (prime_cnt_q == 2'd2) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                active_d = 1'b0;
                number_d = 6'd0;
                if (|pending_q) begin
                    number_d   = {1'b0, lowest_idx} + 6'd1;
                    active_d   = 1'b1;
                    busy_cnt_d = 8'd0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // An acknowledge in the final wait cycle still counts as a normal acknowledge.
                if (resetActive) begin
                    clear_mask = 18'd1 << (number_q - 6'd1);
                    active_d   = 1'b0;
                    number_d   = 6'd0;
                    state_d    = GAP;
                end else if (busy_cnt_q == TIMEOUT_LAST) begin
                    active_d   = 1'b0;
                    number_d   = 6'd0;
                    timeout_d  = 1'b1;
                    state_d    = GAP;
                end else begin
                    busy_cnt_d = busy_cnt_q + 8'd1;
                end
            end
            GAP: begin
                busy_cnt_d = 8'd0;
                state_d    = IDLE;
            end
            default: begin
                state_d = PRIME;
            end
        endcase

        // A fresh toggle on the bit being acknowledged re-arms it rather than coalescing.
        pending_d   = (pending_q & ~clear_mask) | toggle;
        coalesced_d = coalesced_q | (|(toggle & pending_q & ~clear_mask));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PRIME;
            prime_cnt_q <= 2'd0;
            busy_cnt_q  <= 8'd0;
            sync_meta_q <= '0;
            sync_q      <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            number_q    <= 6'd0;
            active_q    <= 1'b0;
            coalesced_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            number_q    <= number_d;
            active_q    <= active_d;
            coalesced_q <= coalesced_d;
            timeout_q   <= timeout_d;
        end
    end

    assign number    = number_q;
    assign active    = active_q;
    assign pending   = pending_q;
    assign coalesced = coalesced_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_switch_event_source.sv
// tb_switch_event_source: scoreboarded bench; expected report numbers come from an
// event-level model (set bits served in ascending order), checked on each rising 'active'.
module tb_switch_event_source;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] switches;
    logic        resetActive;
    logic [5:0]  number;
    logic        active;
    logic [17:0] pending;
    logic        coalesced;
    logic        timeout;

    int          testCount = 0;
    int          failCount = 0;
    int          expQ[$];
    logic [17:0] swState   = 18'h00005;
    logic [17:0] modelPend = '0;
    bit          modelCoal = 1'b0;
    bit          modelTo   = 1'b0;
    bit          ackEnable = 1'b1;
    int          ackDelay  = -1;
    bit          ackSeen   = 1'b0;

    switch_event_source #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .switches    (switches),
        .resetActive (resetActive),
        .number      (number),
        .active      (active),
        .pending     (pending),
        .coalesced   (coalesced),
        .timeout     (timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Toggle the masked switches; a bit already waiting for service only coalesces.
    task automatic applyStimulus(input logic [17:0] mask);
        for (int i = 0; i < 18; i++) begin
            if (mask[i]) begin
                if (modelPend[i]) begin
                    modelCoal = 1'b1;
                end else begin
                    modelPend[i] = 1'b1;
                    expQ.push_back(i + 1);
                end
            end
        end
        swState  = swState ^ mask;
        switches = swState;
    endtask

    task automatic waitActive(input string name, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (active !== 1'b1 && cycles < 60);
        if (active !== 1'b1) begin
            checkOutput({name, " wait for active"}, 32'(active), 32'd1);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput({name, " reports outstanding"}, 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
        repeat (12) @(negedge clk);
        checkOutput({name, " pending"},   32'(pending),   32'd0);
        checkOutput({name, " active"},    32'(active),    32'd0);
        checkOutput({name, " coalesced"}, 32'(coalesced), 32'(modelCoal));
        checkOutput({name, " timeout"},   32'(timeout),   32'(modelTo));
        modelPend = '0;
    endtask

    // Consumer: acknowledge each new report after ackDelay cycles (random when negative).
    initial begin
        int d;
        resetActive = 1'b0;
        forever begin
            @(negedge clk);
            if (active === 1'b1 && !ackSeen && ackEnable) begin
                d = (ackDelay < 0) ? int'($urandom_range(0, 4)) : ackDelay;
                repeat (d) @(negedge clk);
                resetActive = 1'b1;
                @(negedge clk);
                resetActive = 1'b0;
            end
            ackSeen = (active === 1'b1);
        end
    end

    // Monitor: pop the scoreboard on every new report and hold number stable while active.
    initial begin
        bit prevActive = 1'b0;
        int curExp = 0;
        forever begin
            @(negedge clk);
            if (active === 1'b1 && !prevActive) begin
                if (expQ.size() == 0) begin
                    testCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected report: got number %0d, expected no report", number);
                end else begin
                    curExp = expQ.pop_front();
                    checkOutput("report number", 32'(number), 32'(curExp));
                end
            end else if (active === 1'b1 && prevActive) begin
                checkOutput("number stable", 32'(number), 32'(curExp));
            end
            prevActive = (active === 1'b1);
        end
    end

    initial begin
        int cyc;
        int hi;
        switches = swState;
        reset    = 1'b1;
        #1 reset = 1'b0;
        #2;
        checkOutput("reset active",    32'(active),    32'd0);
        checkOutput("reset number",    32'(number),    32'd0);
        checkOutput("reset pending",   32'(pending),   32'd0);
        checkOutput("reset coalesced", 32'(coalesced), 32'd0);
        checkOutput("reset timeout",   32'(timeout),   32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checkOutput("static switches quiet", 32'({pending, active}), 32'd0);
        end

        ackDelay = 3;
        applyStimulus(18'h00008);
        waitActive("bit3", cyc);
        checkOutput("bit3 latency", 32'(cyc), 32'd4);
        repeat (4) @(negedge clk);
        checkOutput("bit3 active after ack",  32'(active),  32'd0);
        checkOutput("bit3 pending after ack", 32'(pending), 32'd0);
        @(negedge clk);
        checkOutput("bit3 gap active", 32'(active), 32'd0);
        drain("bit3");

        ackDelay = -1;
        applyStimulus(18'h20021);
        drain("bits 0/5/17");

        // Re-toggle bit 9 so its detection lands on the acknowledge edge.
        ackDelay = 4;
        applyStimulus(18'h00200);
        waitActive("bit9", cyc);
        repeat (2) @(negedge clk);
        modelPend[9] = 1'b0;
        applyStimulus(18'h00200);
        repeat (3) @(negedge clk);
        checkOutput("set wins pending",   32'(pending),   32'h00200);
        checkOutput("set wins coalesced", 32'(coalesced), 32'd0);
        drain("set wins");

        ackDelay = 6;
        applyStimulus(18'h00001);
        waitActive("bit0", cyc);
        applyStimulus(18'h00004);
        @(negedge clk);
        applyStimulus(18'h00004);
        repeat (3) @(negedge clk);
        checkOutput("coalesce pending",   32'(pending),   32'h00005);
        checkOutput("coalesce coalesced", 32'(coalesced), 32'd1);
        drain("coalesce");

        for (int r = 0; r < 20; r++) begin
            logic [17:0] mask;
            int top;
            ackDelay = -1;
            mask = 18'($urandom) & 18'($urandom);
            if (mask == '0) begin
                mask = 18'd1 << $urandom_range(0, 17);
            end
            applyStimulus(mask);
            if ($countones(mask) >= 2 && $urandom_range(0, 1) == 1) begin
                top = 0;
                for (int i = 0; i < 18; i++) begin
                    if (mask[i]) top = i;
                end
                @(negedge clk);
                applyStimulus(18'd1 << top);
            end
            drain("random");
        end

        // Never acknowledged: the report expires and the same bit is offered again.
        ackEnable = 1'b0;
        applyStimulus(18'h00010);
        expQ.push_back(5);
        modelTo = 1'b1;
        waitActive("bit4", cyc);
        hi = 0;
        while (active === 1'b1 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        checkOutput("timeout active cycles", 32'(hi),      32'(TO));
        checkOutput("timeout flag",          32'(timeout), 32'd1);
        checkOutput("timeout keeps pending", 32'(pending), 32'h00010);
        ackEnable = 1'b1;
        drain("timeout");

        ackEnable = 1'b0;
        applyStimulus(18'h00040);
        waitActive("bit6", cyc);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid-busy reset active",    32'(active),    32'd0);
        checkOutput("mid-busy reset number",    32'(number),    32'd0);
        checkOutput("mid-busy reset pending",   32'(pending),   32'd0);
        checkOutput("mid-busy reset coalesced", 32'(coalesced), 32'd0);
        checkOutput("mid-busy reset timeout",   32'(timeout),   32'd0);
        modelPend = '0;
        modelCoal = 1'b0;
        modelTo   = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        ackEnable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checkOutput("post reset quiet", 32'({pending, active}), 32'd0);
        end
        applyStimulus(18'h00002);
        drain("post reset");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
